channel_sequencer: RTL and testbench
====================================

Name: channel_sequencer

Overview:
- Parametrised successor to the fixed three-motor RGB timer: drives N_CH dispenser motors, each for a programmed number of time units.
- Operates in sequential mode (one channel at a time, in index order) or parallel mode (all channels start together).
- Provides start/abort handshake, per-channel completion flags, a one-cycle done pulse and an abort pulse.
- Sits between the digit memory (supplies the counts) and the top-level FSM (issues start, consumes done).

Parameters:
- N_CH, 3: number of motor channels.
- CNT_W, 5: width of each channel's count, in time units.
- PRESCALE, 20000000: clk cycles per time unit; must be ≥1. PRESCALE=1 gives one unit per clk, for simulation.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled on the clk rising edge; level or pulse.
- abort  in  1  cancel request; has priority over start.
- mode  in  1  0 = sequential, 1 = parallel; sampled only when start is accepted.
- cycles  in  N_CH*CNT_W  count for channel i in bits [i*CNT_W +: CNT_W]; sampled only when start is accepted.
- motors  out  N_CH  motor enables, registered.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a run completes normally.
- aborted  out  1  one-cycle pulse when a run is cancelled.
- ch_done  out  N_CH  sticky flags: channel i completed or was skipped.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; motors, busy, done, aborted, ch_done and all counters go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 at edge k → enter RUN at edge k.
  - At edge k: latch cycles and mode into shadow registers, clear ch_done, clear the prescaler.
  - Channels with a zero count get ch_done[i]=1 at edge k and are never driven.
  - If every count is zero → go to DONE instead of RUN at edge k (done=1 at k, busy stays 0, motors stay 0).
- Prescaler: the tick is asserted every PRESCALE-th clk cycle while in RUN. A channel count of n drives its motor for exactly n*PRESCALE clk cycles.
- RUN, sequential mode:
  - The lowest-index nonzero channel is driven from edge k.
  - When its shadow count reaches 0, at the same edge: its motor drops, ch_done[i] is set, and the next nonzero channel is asserted (no gap between channels; zero channels are skipped).
  - When the last channel finishes → go to DONE, motors=0.
- RUN, parallel mode:
  - All nonzero channels are asserted at edge k.
  - Each channel drops and sets its ch_done bit independently when its own count expires.
  - When all channels have finished → go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. ch_done holds until the next accepted start.
- start while in RUN or DONE: ignored; no queuing.
- abort=1 in RUN:
  - Next edge → IDLE, motors=0, aborted=1 for one cycle, done is not pulsed.
  - ch_done keeps the bits set so far.
- abort=1 in IDLE or DONE: no effect, except that it blocks a simultaneous start. No aborted pulse.
- Count arithmetic: counts are unsigned CNT_W bits, so the maximum time is (2^CNT_W−1)*PRESCALE cycles. Decrements saturate at 0; no wrap-around.
- A change on the cycles input during RUN has no effect; only the shadow registers are used.

Decomposition:
- Shared package/include dispenser_defs holds:
  - state encodings IDLE/RUN/DONE;
  - MODE_SEQ=0 and MODE_PAR=1;
  - a clog2 function used for the prescaler width.
- One sub-module, tick_prescaler (parameter PRESCALE; ports clk, reset, clear, en, tick). It is reused later by the display multiplexer.
- Per-channel count logic is a generate loop, not a separate module.

Test Plan (N_CH=3, CNT_W=5, PRESCALE=2; start pulsed at edge 0):
- Sequential, cycles={B=2,G=0,R=3}:
  - motors=001 edges 0–5, 100 edges 6–9, 000 from edge 10.
  - done=1 at edge 10 only; ch_done=010 at edge 0, 011 at edge 6, 111 at edge 10.
- Parallel, same counts:
  - motors=101 edges 0–3, 001 edges 4–5, 000 at edge 6.
  - done=1 at edge 6; busy=1 edges 0–5.
- All counts zero: done=1 at edge 0, ch_done=111, motors never nonzero, busy never 1.
- Sequential R=3, abort at edge 3:
  - motors=000 at edge 4, aborted=1 at edge 4 only, done never asserted, ch_done=010.
- Control interactions:
  - start repeated at edge 2 during RUN → timing identical to the first scenario.
  - start and abort together in IDLE → stays IDLE, all outputs 0.
- reset=0 mid-run (between edges 3 and 4) → motors, busy and ch_done all go to 0 immediately, without waiting for a clk edge.
- After reset is released, start → a normal run with the first scenario's timing.

Source files
------------

// File: rtl/dispenser_defs.sv
// Shared definitions for the dispenser timing blocks: FSM encoding, run modes
// and a constant-width helper.
package dispenser_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_PAR = 1'b1;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles.
// Also used by the display multiplexer.
module tick_prescaler
  import dispenser_defs::*;
#(
  parameter int unsigned PRESCALE = 20000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/channel_sequencer.sv
// Runs N_CH motors for programmed unit counts, one after another or all at once,
// with start/abort handshake and per-channel completion flags.
module channel_sequencer
  import dispenser_defs::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned PRESCALE = 20000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [N_CH*CNT_W-1:0] cycles,
  output logic [N_CH-1:0]       motors,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [N_CH-1:0]       ch_done
);

  state_e            state_q, state_d;
  logic              mode_q, mode_sel_c;
  logic [N_CH-1:0]   motors_q, motors_d;
  logic [N_CH-1:0]   ch_done_q, ch_done_d;
  logic              busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic              accept_c, tick_c;
  logic [N_CH-1:0]   expire_c, rem_c, lowest_c, run_motors_c;

  assign accept_c = (state_q == ST_IDLE) && start && !abort;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept_c),
    .en    (state_q == ST_RUN),
    .tick  (tick_c)
  );

  // Shadow count per channel; rem_c marks channels still owed run time after this edge.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] load_c, cnt_q, cnt_d;
    logic             active_c;

    assign load_c      = cycles[i*CNT_W +: CNT_W];
    assign active_c    = (state_q == ST_RUN) && motors_q[i];
    assign expire_c[i] = tick_c && active_c && (cnt_q == CNT_W'(1));
    assign rem_c[i]    = accept_c ? (load_c != '0) : ((cnt_q != '0) && !expire_c[i]);

    always_comb begin
      cnt_d = cnt_q;
      if (accept_c) begin
        cnt_d = load_c;
      end else if (tick_c && active_c && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

  // Sequential mode drives only the lowest channel still owed time; finished ones are zero.
  assign lowest_c     = rem_c & (~rem_c + N_CH'(1));
  assign mode_sel_c   = accept_c ? mode : mode_q;
  assign run_motors_c = (mode_sel_c == MODE_PAR) ? rem_c : lowest_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = (rem_c == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)              state_d = ST_IDLE;
        else if (rem_c == '0)   state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    motors_d  = '0;
    busy_d    = 1'b0;
    done_d    = (state_d == ST_DONE);
    aborted_d = (state_q == ST_RUN) && abort;
    ch_done_d = ch_done_q;
    if (accept_c) begin
      ch_done_d = ~rem_c;
    end else if ((state_q == ST_RUN) && !abort) begin
      ch_done_d = ch_done_q | expire_c;
    end
    if (state_d == ST_RUN) begin
      motors_d = run_motors_c;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= MODE_SEQ;
      motors_q  <= '0;
      ch_done_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (accept_c) mode_q <= mode;
      motors_q  <= motors_d;
      ch_done_q <= ch_done_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign motors  = motors_q;
  assign ch_done = ch_done_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed bench for channel_sequencer with N_CH=3, CNT_W=5, PRESCALE=2.
// Edge 0 is the rising edge that samples the accepted start.
module tb_channel_sequencer;

  logic        clk, reset, start, abort, mode;
  logic [14:0] cycles;
  logic [2:0]  motors, ch_done;
  logic        busy, done, aborted;

  integer checks = 0;
  integer errors = 0;

  channel_sequencer #(.N_CH(3), .CNT_W(5), .PRESCALE(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .cycles  (cycles),
    .motors  (motors),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .ch_done (ch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected vectors are packed as {motors, busy, done, aborted, ch_done}.
  task automatic test_reset();
    logic [8:0] obs;
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; cycles = '0;
    step();
    step();
    obs = {motors, busy, done, aborted, ch_done};
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 9'b0);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_start_abort_idle();
    logic [8:0] obs;
    cycles = {5'd2, 5'd0, 5'd3};
    mode = 1'b0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    for (int e = 0; e < 4; e++) begin
      if (e > 0) step();
      obs = {motors, busy, done, aborted, ch_done};
      checks++;
      if (obs !== 9'b0) begin
        errors++;
        $display("FAIL start_abort_idle edge=%0d obs=%b exp=%b", e, obs, 9'b0);
      end
    end
  endtask

  task automatic test_sequential(input string name, input bit restart);
    logic [8:0] obs, exp;
    logic [2:0] em, ecd;
    cycles = {5'd2, 5'd0, 5'd3};
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      if (e > 0) step();
      if (restart && e == 0) begin
        cycles = {5'd7, 5'd7, 5'd7};
        mode   = 1'b1;
      end
      start = (restart && e == 1);
      em  = (e <= 5) ? 3'b001 : (e <= 9) ? 3'b100 : 3'b000;
      ecd = (e < 6) ? 3'b010 : (e < 10) ? 3'b011 : 3'b111;
      exp = {em, 1'(e <= 9), 1'(e == 10), 1'b0, ecd};
      obs = {motors, busy, done, aborted, ch_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s edge=%0d obs=%b exp=%b", name, e, obs, exp);
      end
    end
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic test_parallel();
    logic [8:0] obs, exp;
    logic [2:0] em, ecd;
    cycles = {5'd2, 5'd0, 5'd3};
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      if (e > 0) step();
      em  = (e <= 3) ? 3'b101 : (e <= 5) ? 3'b001 : 3'b000;
      ecd = (e < 4) ? 3'b010 : (e < 6) ? 3'b110 : 3'b111;
      exp = {em, 1'(e <= 5), 1'(e == 6), 1'b0, ecd};
      obs = {motors, busy, done, aborted, ch_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL parallel edge=%0d obs=%b exp=%b", e, obs, exp);
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_all_zero();
    logic [8:0] obs, exp;
    cycles = '0;
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      if (e > 0) step();
      exp = {3'b000, 1'b0, 1'(e == 0), 1'b0, 3'b111};
      obs = {motors, busy, done, aborted, ch_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL all_zero edge=%0d obs=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [8:0] obs, exp;
    cycles = {5'd2, 5'd0, 5'd3};
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      if (e > 0) step();
      abort = (e == 3);
      if (e <= 3) exp = {3'b001, 1'b1, 1'b0, 1'b0, 3'b010};
      else        exp = {3'b000, 1'b0, 1'b0, 1'(e == 4), 3'b010};
      obs = {motors, busy, done, aborted, ch_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort edge=%0d obs=%b exp=%b", e, obs, exp);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [6:0] obs;
    cycles = {5'd2, 5'd0, 5'd3};
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    obs = {motors, busy, ch_done};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 7'b0);
    end
    #1;
    reset = 1'b1;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_start_abort_idle();
    test_sequential("sequential", 1'b0);
    test_parallel();
    test_all_zero();
    test_abort();
    test_sequential("restart_ignored", 1'b1);
    test_async_reset();
    test_sequential("after_reset", 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
